// File: rtl/i2c_target_responder_pkg.sv
// Shared types and constants for the I2C target responder: FSM states,
// default TMP101 address, R/W encoding and the bit-counter helper.
package i2c_target_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_ACK_A = 3'd2,
        ST_RX    = 3'd3,
        ST_ACK_R = 3'd4,
        ST_TX    = 3'd5,
        ST_MACK  = 3'd6
    } state_t;

    localparam logic [6:0] TMP101_ADDRESS = 7'h48;
    localparam logic       RW_WRITE       = 1'b0;
    localparam logic       RW_READ        = 1'b1;
    localparam logic [3:0] ADDR_LAST_BIT  = 4'd7;

    // Saturating increment for the 4-bit bit counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] limit);
        return (cnt >= limit) ? limit : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/i2c_target_responder_bus_sync.sv
// SCL/SDA two-flop synchronizers with registered edge, START and STOP detection.
// Input-to-event latency is three clocks.
module i2c_bus_sync (
    input  logic clock,
    input  logic Reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic scl_meta_r, scl_sync_r, scl_prev_r;
    logic sda_meta_r, sda_sync_r, sda_prev_r;

    // Synchronizer chains; reset to the idle-high bus level so no edge is seen on release.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // Registered bus events; sda_bit is aligned with scl_rise for sampling.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_bit   <= 1'b1;
        end else begin
            scl_rise  <= scl_sync_r & ~scl_prev_r;
            scl_fall  <= ~scl_sync_r & scl_prev_r;
            start_det <= scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
            stop_det  <= scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
            sda_bit   <= sda_sync_r;
        end
    end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: START/STOP detection, 7-bit address match, ACK generation,
// byte receive and byte transmit. SDA is open-drain (0 or Z), no clock stretching.
module i2c_target_responder
    import i2c_target_responder_pkg::*;
#(
    parameter logic [6:0] ADDRESS = TMP101_ADDRESS,
    parameter int         LENGTH  = 8
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              SCL,
    inout  wire               SDA,
    input  logic [LENGTH-1:0] TxData,
    output logic [LENGTH-1:0] RxData,
    output logic              RxValid,
    output logic              TxReq,
    output logic              RnW,
    output logic              Busy
);

    localparam logic [3:0] LEN_CNT  = 4'(LENGTH);
    localparam logic [3:0] LEN_LAST = LEN_CNT - 4'd1;

    logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_bit_s;

    state_t            state_r;
    logic [3:0]        bit_cnt_r;
    logic [6:0]        addr_shift_r;
    logic [LENGTH-2:0] rx_shift_r;
    logic [LENGTH-2:0] tx_shift_r;
    logic              sda_low_r;

    i2c_bus_sync u_sync (
        .clock    (clock),
        .Reset    (Reset),
        .scl      (SCL),
        .sda      (SDA),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .start_det(start_det_s),
        .stop_det (stop_det_s),
        .sda_bit  (sda_bit_s)
    );

    assign SDA = sda_low_r ? 1'b0 : 1'bz;

    // Protocol FSM: sample on SCL rise, change SDA drive on SCL fall; START/STOP win over edges.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 4'd0;
            addr_shift_r <= 7'd0;
            rx_shift_r   <= '0;
            tx_shift_r   <= '0;
            sda_low_r    <= 1'b0;
            RxData       <= '0;
            RxValid      <= 1'b0;
            TxReq        <= 1'b0;
            RnW          <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            RxValid <= 1'b0;
            TxReq   <= 1'b0;
            if (start_det_s) begin
                state_r   <= ST_ADDR;
                bit_cnt_r <= 4'd0;
                sda_low_r <= 1'b0;
                Busy      <= 1'b0;
            end else if (stop_det_s) begin
                state_r   <= ST_IDLE;
                sda_low_r <= 1'b0;
                Busy      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_low_r <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            addr_shift_r <= {addr_shift_r[5:0], sda_bit_s};
                            if (bit_cnt_r == ADDR_LAST_BIT) begin
                                bit_cnt_r <= 4'd0;
                                if (addr_shift_r == ADDRESS) begin
                                    RnW     <= sda_bit_s;
                                    Busy    <= 1'b1;
                                    state_r <= ST_ACK_A;
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end else begin
                                bit_cnt_r <= sat_inc(bit_cnt_r, LEN_CNT);
                            end
                        end
                    end
                    ST_ACK_A: begin
                        // First fall starts the ACK; the second fall ends the ACK clock.
                        if (scl_fall_s) begin
                            if (!sda_low_r) begin
                                sda_low_r <= 1'b1;
                            end else if (RnW == RW_WRITE) begin
                                sda_low_r <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_RX;
                            end else begin
                                TxReq      <= 1'b1;
                                tx_shift_r <= TxData[LENGTH-2:0];
                                sda_low_r  <= ~TxData[LENGTH-1];
                                bit_cnt_r  <= 4'd1;
                                state_r    <= ST_TX;
                            end
                        end
                    end
                    ST_RX: begin
                        if (scl_rise_s) begin
                            rx_shift_r <= {rx_shift_r[LENGTH-3:0], sda_bit_s};
                            if (bit_cnt_r == LEN_LAST) begin
                                RxData    <= {rx_shift_r, sda_bit_s};
                                RxValid   <= 1'b1;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_ACK_R;
                            end else begin
                                bit_cnt_r <= sat_inc(bit_cnt_r, LEN_CNT);
                            end
                        end
                    end
                    ST_ACK_R: begin
                        if (scl_fall_s) begin
                            if (!sda_low_r) begin
                                sda_low_r <= 1'b1;
                            end else begin
                                sda_low_r <= 1'b0;
                                state_r   <= ST_RX;
                            end
                        end
                    end
                    ST_TX: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == LEN_CNT) begin
                                sda_low_r <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_MACK;
                            end else begin
                                sda_low_r  <= ~tx_shift_r[LENGTH-2];
                                tx_shift_r <= {tx_shift_r[LENGTH-3:0], 1'b0};
                                bit_cnt_r  <= sat_inc(bit_cnt_r, LEN_CNT);
                            end
                        end
                    end
                    ST_MACK: begin
                        // A fall here always follows an ACK rise, since a NACK rise leaves the state.
                        if (scl_rise_s && sda_bit_s) begin
                            Busy    <= 1'b0;
                            state_r <= ST_IDLE;
                        end else if (scl_fall_s) begin
                            TxReq      <= 1'b1;
                            tx_shift_r <= TxData[LENGTH-2:0];
                            sda_low_r  <= ~TxData[LENGTH-1];
                            bit_cnt_r  <= 4'd1;
                            state_r    <= ST_TX;
                        end
                    end
                    default: begin
                        sda_low_r <= 1'b0;
                        Busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bus master model drives SCL/SDA,
// received bytes go through an expected-value scoreboard.
module tb_i2c_target_responder;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    wire        sda_line;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       rnw;
    logic       busy;

    logic [7:0] tx_tab [0:3];
    int         tx_idx = 0;
    logic [7:0] rx_obs [0:15];
    int         rx_obs_cnt = 0;
    int         txreq_cnt  = 0;
    int         rx_chk     = 0;
    logic [7:0] exp_rx [$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    pullup (sda_line);
    assign sda_line = sda_m ? 1'bz : 1'b0;
    assign tx_data  = tx_tab[tx_idx[1:0]];

    i2c_target_responder #(.ADDRESS(7'h48), .LENGTH(8)) dut (
        .clock  (clk),
        .Reset  (rst_n),
        .SCL    (scl_m),
        .SDA    (sda_line),
        .TxData (tx_data),
        .RxData (rx_data),
        .RxValid(rx_valid),
        .TxReq  (tx_req),
        .RnW    (rnw),
        .Busy   (busy)
    );

    // Record DUT output events away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_obs[rx_obs_cnt[3:0]] <= rx_data;
            rx_obs_cnt <= rx_obs_cnt + 1;
        end
        if (tx_req === 1'b1) begin
            txreq_cnt <= txreq_cnt + 1;
            tx_idx    <= tx_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        while (rx_chk < rx_obs_cnt && exp_rx.size() > 0) begin
            check({tag, "_rxdata"}, 32'(rx_obs[rx_chk[3:0]]), 32'(exp_rx.pop_front()));
            rx_chk++;
        end
        check({tag, "_rx_extra"}, 32'(rx_obs_cnt - rx_chk), 32'd0);
        check({tag, "_rx_missing"}, 32'(exp_rx.size()), 32'd0);
        rx_chk = rx_obs_cnt;
        exp_rx.delete();
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b;
        wait_clk(H);
        scl_m = 1'b1;
        wait_clk(H / 2);
        r = sda_line;
        wait_clk(H / 2);
        scl_m = 1'b0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_clk(H);
        scl_m = 1'b1;
        wait_clk(H);
        sda_m = 1'b0;
        wait_clk(H);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clk(H);
        scl_m = 1'b1;
        wait_clk(H);
        sda_m = 1'b1;
        wait_clk(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(~mack, r);
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] d;
        int         tr0;

        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tx_tab[0] = 8'hA5;
        tx_tab[1] = 8'h3C;
        tx_tab[2] = 8'hC3;
        tx_tab[3] = 8'h00;
        wait_clk(5);
        check("rst_sda", 32'(sda_line), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rnw", 32'(rnw), 32'd0);
        check("rst_rxvalid", 32'(rx_valid), 32'd0);
        check("rst_txreq", 32'(tx_req), 32'd0);
        check("rst_rxdata", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        // 1: reset mid data byte
        bus_start();
        write_byte(8'h90, ack);
        check("t1_addr_ack", 32'(ack), 32'd1);
        bus_bit(1'b1, r);
        bus_bit(1'b0, r);
        bus_bit(1'b1, r);
        rst_n = 1'b0;
        wait_clk(3);
        check("t1_sda", 32'(sda_line), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_rxdata", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        sda_m = 1'b1;
        wait_clk(H);
        scl_m = 1'b1;
        wait_clk(H);
        drain("t1");

        // 2: simple write
        bus_start();
        write_byte(8'h90, ack);
        check("t2_addr_ack", 32'(ack), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_rnw", 32'(rnw), 32'd0);
        exp_rx.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check("t2_data_ack", 32'(ack), 32'd1);
        bus_stop();
        wait_clk(6);
        check("t2_busy_stop", 32'(busy), 32'd0);
        drain("t2");

        // 3: address mismatch, then a matching address
        bus_start();
        write_byte(8'h92, ack);
        check("t3_nomatch_ack", 32'(ack), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        bus_start();
        write_byte(8'h90, ack);
        check("t3_match_ack", 32'(ack), 32'd1);
        bus_stop();
        wait_clk(6);
        drain("t3");

        // 4: two-byte read, ACK then NACK
        tr0 = txreq_cnt;
        bus_start();
        write_byte(8'h91, ack);
        check("t4_addr_ack", 32'(ack), 32'd1);
        check("t4_rnw", 32'(rnw), 32'd1);
        read_byte(1'b1, d);
        check("t4_byte1", 32'(d), 32'hA5);
        read_byte(1'b0, d);
        check("t4_byte2", 32'(d), 32'h3C);
        wait_clk(6);
        check("t4_sda_released", 32'(sda_line), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_txreq_count", 32'(txreq_cnt - tr0), 32'd2);
        bus_stop();
        wait_clk(6);
        drain("t4");

        // 5: write, repeated START, read
        bus_start();
        write_byte(8'h90, ack);
        check("t5_waddr_ack", 32'(ack), 32'd1);
        exp_rx.push_back(8'h01);
        write_byte(8'h01, ack);
        check("t5_data_ack", 32'(ack), 32'd1);
        check("t5_rnw_write", 32'(rnw), 32'd0);
        bus_start();
        write_byte(8'h91, ack);
        check("t5_raddr_ack", 32'(ack), 32'd1);
        check("t5_rnw_read", 32'(rnw), 32'd1);
        read_byte(1'b0, d);
        check("t5_read", 32'(d), 32'hC3);
        bus_stop();
        wait_clk(6);
        check("t5_rxdata", 32'(rx_data), 32'h01);
        drain("t5");

        // 6: STOP after three bits of a data byte
        bus_start();
        write_byte(8'h90, ack);
        check("t6_addr_ack", 32'(ack), 32'd1);
        bus_bit(1'b0, r);
        bus_bit(1'b1, r);
        bus_bit(1'b1, r);
        bus_stop();
        wait_clk(4);
        check("t6_sda", 32'(sda_line), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
